uart_axis_fifo: RTL and testbench
=================================

# uart_axis_fifo

AXI-Stream byte FIFO placed directly upstream of the UART transmitter. It buffers bursts from the system AXIS master so that producers are not throttled to the line rate, and presents them to the transmitter's `slv_axis_*` port. It optionally holds data until a complete packet (tlast-terminated) is stored, and reports its fill level for status and flow control.

## Interface
Parameters:
- `DATA_WIDTH`, 8, tdata width in bits.
- `DEPTH`, 16, number of entries; a power of two, 4..256.
- `AFULL_LEVEL`, DEPTH-2, level at or above which `afull_o` is asserted.

Ports:
- `clk_i` in 1: the only clock.
- `rst_n_i` in 1: reset, **synchronous, active-low**.
- `flush_i` in 1: synchronous clear of contents; keeps configuration.
- `slv_axis_tdata_i` in DATA_WIDTH: write data from the system.
- `slv_axis_tvalid_i` in 1: write valid.
- `slv_axis_tlast_i` in 1: last byte of a packet.
- `slv_axis_tready_o` out 1: FIFO not full and not flushing.
- `mst_axis_tdata_o` out DATA_WIDTH: head entry data, to the transmitter.
- `mst_axis_tvalid_o` out 1: head entry available for release.
- `mst_axis_tlast_o` out 1: head entry's stored tlast.
- `mst_axis_tready_i` in 1: transmitter accepts.
- `level_o` out $clog2(DEPTH)+1: current entry count, 0..DEPTH.
- `empty_o` out 1, `full_o` out 1, `afull_o` out 1: status flags.

## Operation
- Storage: DEPTH × (DATA_WIDTH+1) array, holding tdata and tlast.
- Pointers: `wr_ptr`/`rd_ptr` are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
- `level_o` = wr_ptr − rd_ptr, modulo 2^(AW+1).
- Write beat: `slv_axis_tvalid_i && slv_axis_tready_o`. Stores {tlast, tdata} at wr_ptr and increments wr_ptr.
- Read beat: `mst_axis_tvalid_o && mst_axis_tready_i`. Increments rd_ptr.
- `mst_axis_tdata_o`/`tlast_o` are a combinational read of mem[rd_ptr low bits]. They are stable while valid and not ready, per AXIS rules.
- Simultaneous read and write in the same cycle: both occur; level is unchanged.
  - When full, `tready_o` is 0, so no write occurs even if a read occurs that cycle. No combinational path from `tready_i` to `tready_o`.
  - When empty, `tvalid_o` is 0, so no read occurs. There is no write-through bypass.
- `flush_i`: both pointers are set to 0 the next edge. The packet counter is cleared. Beats presented in the flush cycle are neither accepted nor released (`tready_o` = 0, `tvalid_o` = 0 while `flush_i` = 1).
- Reset values:
  - `slv_axis_tready_o` = 0 during reset, then 1 the cycle after reset release.
  - `mst_axis_tvalid_o` = 0, `mst_axis_tlast_o` = 0, `mst_axis_tdata_o` = 0 (array reset is not required, but the output is masked to 0 when empty).
  - `level_o` = 0, `empty_o` = 1, `full_o` = 0, `afull_o` = 0.
- Reset mid-transfer discards all contents; no partial beat survives.

## Timing
- Write-to-read latency: a byte written at edge N is visible at `mst_axis_*` in the cycle after edge N (1 cycle).
- Throughput: 1 beat/cycle in and 1 beat/cycle out, sustained.
- Flags and `level_o` are registered-pointer derived. They update in the cycle after the causing beat.
- `tready_o` depends only on registered state and `flush_i`.

## Configuration
- `UART_FIFO_PKT_MODE_EN` defined: packet mode.
  - A `pkt_cnt` register (width as `level_o`) increments on each write beat with tlast=1 and decrements on each read beat with tlast=1. If both happen in the same cycle, it is unchanged.
  - `mst_axis_tvalid_o` = !empty && (pkt_cnt != 0 || full). The full override prevents deadlock on packets longer than DEPTH.
  - Once a packet's first byte is released, release continues byte-by-byte until its tlast, even if pkt_cnt would otherwise block. An `in_pkt` flag is set on a read without tlast and cleared on a read with tlast.
- Not defined: no `pkt_cnt` or `in_pkt` logic; `mst_axis_tvalid_o` = !empty.

## Structure
- `uart_pkg`:
  - `uart_fifo_entry_t` (packed struct {tlast, tdata}).
  - default DEPTH constant.
  - `clog2`-based pointer-width localparam helper.
- Sub-module `uart_fifo_mem`: simple dual-port array with synchronous write and asynchronous read, parameterised on width and depth.
- Top-level FIFO contains the pointers, flags, and packet logic.

## Test plan
- Reset, then write 0x41, 0x42, 0x43 with tready_i=1:
  - Bytes appear in order, each 1 cycle after its write.
  - `level_o` peaks at 1; `empty_o` returns to 1.
- Hold tready_i=0 and write DEPTH bytes 0x00..0x0F:
  - `full_o`=1 and `tready_o`=0 after the 16th write; `afull_o` rises at level 14.
  - Then release: 16 bytes out in order, pointers wrap, `level_o` reaches 0.
- At level 8, simultaneous read and write for 20 cycles:
  - `level_o` stays 8 throughout; data order is preserved across wrap.
- Write 5 bytes, pulse `flush_i` with tvalid_i=1:
  - Flush-cycle beat not accepted; next cycle `level_o`=0, `empty_o`=1, `tvalid_o`=0.
- PKT_MODE_EN, tready_i=1:
  - Write 0x10, 0x11 (no tlast): `tvalid_o` stays 0.
  - Write 0x12 with tlast: 3 bytes released back-to-back, tlast on 0x12.
  - Also write 20 bytes without tlast: release starts when full.
- Assert `rst_n_i`=0 with 6 bytes stored:
  - Next cycle all outputs are at their reset values.
  - After release, old data is never emitted.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit-side AXIS FIFO.
//   UART_DATA_WIDTH   : default tdata width
//   UART_FIFO_DEPTH   : default FIFO depth (power of two)
//   uart_fifo_entry_t : stored entry layout {tlast, tdata} at the default width
//   uart_ptr_width()  : pointer width for a given depth (index bits + wrap bit)
package uart_pkg;

    localparam int UART_DATA_WIDTH = 8;
    localparam int UART_FIFO_DEPTH = 16;

    typedef struct packed {
        logic                       tlast;
        logic [UART_DATA_WIDTH-1:0] tdata;
    } uart_fifo_entry_t;

    // One extra MSB distinguishes full from empty when the index bits match.
    function automatic int uart_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uart_axis_fifo_if.sv
// uart_axis_fifo_if: one AXI-Stream byte channel.
//   tdata  : payload
//   tvalid : source has a beat
//   tlast  : beat ends a packet
//   tready : sink accepts
// Modports: master drives tdata/tvalid/tlast, slave drives tready.
interface uart_axis_fifo_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tlast;
    logic                  tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);

endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: simple dual-port storage, synchronous write, asynchronous read.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write word
//   raddr : read index
//   rdata : word at raddr (combinational)
// The array has no reset; the FIFO masks its output while empty.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_DATA_WIDTH + 1,
    parameter int DEPTH = UART_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_axis_fifo.sv
// uart_axis_fifo: AXI-Stream byte FIFO in front of the UART transmitter.
//   clk_i     : clock
//   rst_n_i   : synchronous active-low reset
//   flush_i   : synchronous clear of contents
//   slv_axis  : upstream stream from the system (slave modport)
//   mst_axis  : downstream stream to the transmitter (master modport)
//   level_o   : entry count 0..DEPTH
//   empty_o / full_o / afull_o : status flags (afull at level >= AFULL_LEVEL)
// Optional build macro UART_FIFO_PKT_MODE_EN: hold data until a complete
// tlast-terminated packet is stored (or the FIFO is full).
module uart_axis_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = UART_DATA_WIDTH,
    parameter int DEPTH       = UART_FIFO_DEPTH,
    parameter int AFULL_LEVEL = DEPTH - 2
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   flush_i,
    uart_axis_fifo_if.slave        slv_axis,
    uart_axis_fifo_if.master       mst_axis,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   empty_o,
    output logic                   full_o,
    output logic                   afull_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = uart_ptr_width(DEPTH);

    typedef struct packed {
        logic                  tlast;
        logic [DATA_WIDTH-1:0] tdata;
    } entry_t;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          ready_q;
    logic          empty;
    logic          full;
    logic          slv_ready;
    logic          mst_valid;
    logic          release_ok;
    logic          wr_beat;
    logic          rd_beat;
    entry_t        wr_entry;
    entry_t        rd_entry;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // ready_q keeps tready low through reset and raises it one cycle after
    // release; tready never looks at the downstream tready.
    assign slv_ready = ready_q && !full && !flush_i;
    assign mst_valid = !empty && !flush_i && release_ok;

    assign wr_beat = slv_axis.tvalid && slv_ready;
    assign rd_beat = mst_valid && mst_axis.tready;

    assign wr_entry.tlast = slv_axis.tlast;
    assign wr_entry.tdata = slv_axis.tdata;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_q <= 1'b0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_q <= 1'b1;
        end else begin
            ready_q <= 1'b1;
            if (wr_beat) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_beat) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    uart_fifo_mem #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk_i),
        .we    (wr_beat),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_entry)
    );

`ifdef UART_FIFO_PKT_MODE_EN
    logic [PW-1:0] pkt_cnt;
    logic          in_pkt;
    logic          pkt_inc;
    logic          pkt_dec;

    assign pkt_inc = wr_beat && slv_axis.tlast;
    assign pkt_dec = rd_beat && rd_entry.tlast;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            pkt_cnt <= '0;
            in_pkt  <= 1'b0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + PW'(1);
                2'b01:   pkt_cnt <= pkt_cnt - PW'(1);
                default: pkt_cnt <= pkt_cnt;
            endcase
            if (rd_beat) begin
                in_pkt <= !rd_entry.tlast;
            end
        end
    end

    // Full overrides the packet gate so a packet longer than DEPTH cannot
    // deadlock; in_pkt then keeps the rest of that packet flowing.
    assign release_ok = (pkt_cnt != '0) || full || in_pkt;
`else
    assign release_ok = 1'b1;
`endif

    // Stale array contents never leak out while empty.
    assign mst_axis.tvalid = mst_valid;
    assign mst_axis.tdata  = empty ? '0 : rd_entry.tdata;
    assign mst_axis.tlast  = !empty && rd_entry.tlast;
    assign slv_axis.tready = slv_ready;

    assign level_o = wr_ptr - rd_ptr;
    assign empty_o = empty;
    assign full_o  = full;
    assign afull_o = (level_o >= PW'(AFULL_LEVEL));

endmodule

// File: tb/tb_uart_axis_fifo.sv
module tb_uart_axis_fifo;

    localparam int DEPTH = 16;
    localparam int AFULL = DEPTH - 2;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic [$clog2(DEPTH):0] level;
    logic empty, full, afull;

    uart_axis_fifo_if #(.DATA_WIDTH(8)) slv_if ();
    uart_axis_fifo_if #(.DATA_WIDTH(8)) mst_if ();

    uart_axis_fifo #(
        .DATA_WIDTH  (8),
        .DEPTH       (DEPTH),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .flush_i  (flush),
        .slv_axis (slv_if),
        .mst_axis (mst_if),
        .level_o  (level),
        .empty_o  (empty),
        .full_o   (full),
        .afull_o  (afull)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the FIFO is a queue of {tlast, data}; a packet is
    // releasable when any stored entry carries tlast.
    logic [8:0] q[$];
    bit         in_pkt_m = 1'b0;
    bit         rdy_en   = 1'b0;

    function automatic bit m_has_last();
        for (int i = 0; i < q.size(); i++) if (q[i][8]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_tvalid();
        if (flush || q.size() == 0) return 1'b0;
`ifdef UART_FIFO_PKT_MODE_EN
        return m_has_last() || q.size() == DEPTH || in_pkt_m;
`else
        return 1'b1;
`endif
    endfunction

    function automatic bit m_tready();
        return rdy_en && !flush && q.size() < DEPTH;
    endfunction

    function automatic logic [7:0] m_tdata();
        return (q.size() > 0) ? q[0][7:0] : 8'h00;
    endfunction

    function automatic bit m_tlast();
        return (q.size() > 0) ? q[0][8] : 1'b0;
    endfunction

    function automatic bit gen_last();
`ifdef UART_FIFO_PKT_MODE_EN
        return 1'b1;
`else
        return 1'($urandom_range(0, 1));
`endif
    endfunction

    // Advance one clock and move the model by the beats the rules allow.
    task automatic tick();
        bit wb, rb;
        logic [8:0] e;
        wb = slv_if.tvalid && m_tready();
        rb = mst_if.tready && m_tvalid();
        @(posedge clk);
        if (!rst_n) begin
            q.delete(); in_pkt_m = 1'b0; rdy_en = 1'b0;
        end else if (flush) begin
            q.delete(); in_pkt_m = 1'b0; rdy_en = 1'b1;
        end else begin
            if (rb) begin
                e = q.pop_front();
                in_pkt_m = !e[8];
            end
            if (wb) q.push_back({slv_if.tlast, slv_if.tdata});
            rdy_en = 1'b1;
        end
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        slv_if.tvalid = 1'b0;
        mst_if.tready = 1'b1;
        while (q.size() > 0 && n < 4 * DEPTH) begin
            #1;
            checks++;
            if (mst_if.tvalid !== m_tvalid()) begin
                errors++; $display("FAIL %s_drain_tvalid: got %b expected %b", tag, mst_if.tvalid, m_tvalid());
            end
            checks++;
            if (mst_if.tdata !== m_tdata()) begin
                errors++; $display("FAIL %s_drain_tdata: got %h expected %h", tag, mst_if.tdata, m_tdata());
            end
            tick();
            n++;
        end
        checks++;
        if (q.size() != 0 || empty !== 1'b1) begin
            errors++; $display("FAIL %s_drain_done: got %0d entries left expected 0", tag, q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        slv_if.tvalid = 1'b0; slv_if.tdata = 8'h00; slv_if.tlast = 1'b0;
        mst_if.tready = 1'b0;
        tick(); tick();
        checks++;
        if ({slv_if.tready, mst_if.tvalid, mst_if.tlast, empty, full, afull} !== 6'b000100) begin
            errors++; $display("FAIL reset_flags: got %b expected 000100",
                {slv_if.tready, mst_if.tvalid, mst_if.tlast, empty, full, afull});
        end
        checks++;
        if (mst_if.tdata !== 8'h00 || level !== '0) begin
            errors++; $display("FAIL reset_data_level: got %h/%0d expected 00/0", mst_if.tdata, level);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (slv_if.tready !== 1'b1) begin
            errors++; $display("FAIL reset_release_tready: got %b expected 1", slv_if.tready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] bytes [3];
        int peak = 0;
        bytes[0] = 8'h41; bytes[1] = 8'h42; bytes[2] = 8'h43;
        mst_if.tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            slv_if.tvalid = 1'b1; slv_if.tdata = bytes[i]; slv_if.tlast = gen_last();
            #1;
            checks++;
            if (slv_if.tready !== m_tready()) begin
                errors++; $display("FAIL basic_tready: got %b expected %b", slv_if.tready, m_tready());
            end
            tick();
            slv_if.tvalid = 1'b0;
            #1;
            if (int'(level) > peak) peak = int'(level);
            checks++;
            if (mst_if.tvalid !== 1'b1 || mst_if.tdata !== bytes[i] || mst_if.tlast !== m_tlast()) begin
                errors++; $display("FAIL basic_out: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                    mst_if.tvalid, mst_if.tdata, mst_if.tlast, bytes[i], m_tlast());
            end
            tick();
        end
        checks++;
        if (peak != 1 || empty !== 1'b1 || level !== '0) begin
            errors++; $display("FAIL basic_level: got peak=%0d empty=%b expected peak=1 empty=1", peak, empty);
        end
    endtask

    task automatic test_fill();
        mst_if.tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slv_if.tvalid = 1'b1; slv_if.tdata = 8'(i); slv_if.tlast = gen_last();
            #1;
            checks++;
            if (slv_if.tready !== m_tready()) begin
                errors++; $display("FAIL fill_tready: got %b expected %b", slv_if.tready, m_tready());
            end
            tick();
            checks++;
            if (level !== 5'(q.size()) || afull !== (q.size() >= AFULL) || full !== (q.size() == DEPTH)) begin
                errors++; $display("FAIL fill_flags: got lvl=%0d af=%b f=%b expected lvl=%0d af=%b f=%b",
                    level, afull, full, q.size(), q.size() >= AFULL, q.size() == DEPTH);
            end
        end
        slv_if.tdata = 8'hEE;
        #1;
        checks++;
        if (slv_if.tready !== 1'b0) begin
            errors++; $display("FAIL fill_full_tready: got %b expected 0", slv_if.tready);
        end
        tick();
        checks++;
        if (level !== 5'(DEPTH)) begin
            errors++; $display("FAIL fill_overflow: got %0d expected %0d", level, DEPTH);
        end
        slv_if.tvalid = 1'b0; mst_if.tready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (mst_if.tvalid !== 1'b1 || mst_if.tdata !== 8'(i) || mst_if.tlast !== m_tlast()) begin
                errors++; $display("FAIL fill_release: got v=%b d=%h expected v=1 d=%h", mst_if.tvalid, mst_if.tdata, 8'(i));
            end
            tick();
        end
        checks++;
        if (level !== '0 || empty !== 1'b1) begin
            errors++; $display("FAIL fill_end: got lvl=%0d empty=%b expected 0/1", level, empty);
        end
    endtask

    task automatic test_concurrent();
        mst_if.tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            slv_if.tvalid = 1'b1; slv_if.tdata = 8'($urandom); slv_if.tlast = gen_last();
            tick();
        end
        mst_if.tready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            slv_if.tdata = 8'($urandom); slv_if.tlast = gen_last();
            #1;
            checks++;
            if (mst_if.tvalid !== m_tvalid() || mst_if.tdata !== m_tdata()) begin
                errors++; $display("FAIL conc_out: got v=%b d=%h expected v=%b d=%h",
                    mst_if.tvalid, mst_if.tdata, m_tvalid(), m_tdata());
            end
            tick();
            checks++;
            if (level !== 5'd8) begin
                errors++; $display("FAIL conc_level: got %0d expected 8", level);
            end
        end
        drain("conc");
    endtask

    task automatic test_flush();
        mst_if.tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            slv_if.tvalid = 1'b1; slv_if.tdata = 8'($urandom); slv_if.tlast = 1'b1;
            tick();
        end
        flush = 1'b1; slv_if.tdata = 8'h77; mst_if.tready = 1'b1;
        #1;
        checks++;
        if (slv_if.tready !== 1'b0 || mst_if.tvalid !== 1'b0) begin
            errors++; $display("FAIL flush_cycle: got rdy=%b vld=%b expected 0/0", slv_if.tready, mst_if.tvalid);
        end
        tick();
        flush = 1'b0; slv_if.tvalid = 1'b0;
        #1;
        checks++;
        if (level !== '0 || empty !== 1'b1 || mst_if.tvalid !== 1'b0) begin
            errors++; $display("FAIL flush_after: got lvl=%0d empty=%b vld=%b expected 0/1/0", level, empty, mst_if.tvalid);
        end
    endtask

`ifdef UART_FIFO_PKT_MODE_EN
    task automatic test_pkt();
        int acc = 0, n = 0;
        mst_if.tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            slv_if.tvalid = 1'b1; slv_if.tdata = 8'h10 + 8'(k); slv_if.tlast = (k == 2);
            #1;
            checks++;
            if (mst_if.tvalid !== 1'b0) begin
                errors++; $display("FAIL pkt_hold: got %b expected 0", mst_if.tvalid);
            end
            tick();
        end
        slv_if.tvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (mst_if.tvalid !== 1'b1 || mst_if.tdata !== 8'h10 + 8'(k) || mst_if.tlast !== (k == 2)) begin
                errors++; $display("FAIL pkt_release: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                    mst_if.tvalid, mst_if.tdata, mst_if.tlast, 8'h10 + 8'(k), k == 2);
            end
            tick();
        end
        while (acc < 20 && n < 200) begin
            slv_if.tvalid = 1'b1; slv_if.tdata = 8'h80 + 8'(acc); slv_if.tlast = 1'b0;
            #1;
            checks++;
            if (mst_if.tvalid !== m_tvalid() || slv_if.tready !== m_tready()) begin
                errors++; $display("FAIL pkt_long: got v=%b r=%b expected v=%b r=%b",
                    mst_if.tvalid, slv_if.tready, m_tvalid(), m_tready());
            end
            if (m_tvalid()) begin
                checks++;
                if (mst_if.tdata !== m_tdata()) begin
                    errors++; $display("FAIL pkt_long_data: got %h expected %h", mst_if.tdata, m_tdata());
                end
            end
            if (m_tready()) acc++;
            tick();
            n++;
        end
        checks++;
        if (acc != 20) begin
            errors++; $display("FAIL pkt_long_timeout: got %0d accepted expected 20", acc);
        end
        slv_if.tdata = 8'h9F; slv_if.tlast = 1'b1;
        tick();
        drain("pkt");
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            slv_if.tvalid = ($urandom_range(0, 3) != 0);
            slv_if.tdata  = 8'($urandom);
            slv_if.tlast  = ($urandom_range(0, 3) == 0);
            mst_if.tready = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 59) == 0);
            #1;
            checks++;
            if (slv_if.tready !== m_tready() || mst_if.tvalid !== m_tvalid()) begin
                errors++; $display("FAIL rand_handshake: got r=%b v=%b expected r=%b v=%b",
                    slv_if.tready, mst_if.tvalid, m_tready(), m_tvalid());
            end
            checks++;
            if (mst_if.tdata !== m_tdata() || mst_if.tlast !== m_tlast()) begin
                errors++; $display("FAIL rand_head: got %h/%b expected %h/%b",
                    mst_if.tdata, mst_if.tlast, m_tdata(), m_tlast());
            end
            checks++;
            if (level !== 5'(q.size()) || empty !== (q.size() == 0) ||
                full !== (q.size() == DEPTH) || afull !== (q.size() >= AFULL)) begin
                errors++; $display("FAIL rand_status: got lvl=%0d e=%b f=%b af=%b expected lvl=%0d",
                    level, empty, full, afull, q.size());
            end
            tick();
        end
        flush = 1'b1; slv_if.tvalid = 1'b0;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        mst_if.tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            slv_if.tvalid = 1'b1; slv_if.tdata = 8'hC0 + 8'(i); slv_if.tlast = 1'b1;
            tick();
        end
        rst_n = 1'b0; slv_if.tdata = 8'h55;
        tick();
        slv_if.tvalid = 1'b0;
        #1;
        checks++;
        if ({slv_if.tready, mst_if.tvalid, mst_if.tlast, empty, full, afull} !== 6'b000100 ||
            mst_if.tdata !== 8'h00 || level !== '0) begin
            errors++; $display("FAIL rstmid_outputs: got flags=%b d=%h lvl=%0d expected 000100/00/0",
                {slv_if.tready, mst_if.tvalid, mst_if.tlast, empty, full, afull}, mst_if.tdata, level);
        end
        rst_n = 1'b1;
        tick();
        mst_if.tready = 1'b1;
        slv_if.tvalid = 1'b1; slv_if.tdata = 8'hA5; slv_if.tlast = 1'b1;
        tick();
        slv_if.tvalid = 1'b0;
        #1;
        checks++;
        if (mst_if.tvalid !== 1'b1 || mst_if.tdata !== 8'hA5) begin
            errors++; $display("FAIL rstmid_new: got v=%b d=%h expected v=1 d=a5", mst_if.tvalid, mst_if.tdata);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mst_if.tvalid !== 1'b0 || empty !== 1'b1) begin
                errors++; $display("FAIL rstmid_stale: got v=%b d=%h expected v=0", mst_if.tvalid, mst_if.tdata);
            end
            tick();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_concurrent();
        test_flush();
`ifdef UART_FIFO_PKT_MODE_EN
        test_pkt();
`endif
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
